bit_scan_unit: RTL and testbench
================================

BIT_SCAN_UNIT -- requirements
Module: bit_scan_unit

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  mask offered.
REQ-004 SHALL have port: in_ready  output  1  unit can accept a mask.
REQ-005 SHALL have port: in_mask  input  32  bit mask to decompose into indices.
REQ-006 SHALL have port: out_valid  output  1  out_index holds a valid set-bit index.
REQ-007 SHALL have port: out_ready  input  1  consumer takes out_index this cycle.
REQ-008 SHALL have port: out_index  output  5  position of lowest remaining set bit.
REQ-009 SHALL have port: out_last  output  1  current index is the final set bit of the mask.
REQ-010 SHALL have port: zero_mask  output  1  one-cycle pulse; the accepted mask was all zeros.
REQ-011 SHALL have port: busy  output  1  high while in SCAN.
REQ-012 SHALL have port (BIT_SCAN_COUNT_EN only): pop_count  output  6  number of set bits in the last accepted mask.

Function
REQ-013 SHALL implement two states: IDLE and SCAN; the state SHALL be held in a register.
REQ-014 In IDLE, in_ready SHALL be 1, and out_valid and busy SHALL be 0.
REQ-015 A mask SHALL be accepted on a clock edge only when in_valid=1 and in_ready=1.
- Nonzero mask: load into the 32-bit mask register, then go to SCAN.
- Zero mask: stay in IDLE and assert zero_mask for exactly the following cycle.
REQ-016 Latency SHALL be fixed: mask accepted at edge N means out_valid=1 during cycle N+1.
REQ-017 In SCAN, in_ready SHALL be 0, busy SHALL be 1 and out_valid SHALL be 1.
- out_index SHALL equal the position of the lowest set bit of the mask register.
- out_last SHALL be 1 exactly when the register has one bit set.
REQ-018 On an edge with out_valid=1 and out_ready=1, the reported bit SHALL be cleared from the mask register.
- If out_last=1, the state SHALL return to IDLE.
- Otherwise it SHALL stay in SCAN with the next-lowest index.
REQ-019 While out_ready=0, out_index, out_last and the mask register SHALL hold stable.
REQ-020 Indices SHALL be emitted in strictly ascending order; each set bit SHALL be emitted exactly once.
REQ-021 Boundary: mask 32'h80000000 SHALL yield a single index 31 with out_last=1.
REQ-022 Boundary: mask 32'hFFFFFFFF SHALL yield 32 indices, 0 through 31; out_last SHALL be 1 only on index 31.
REQ-023 The unit SHALL return to IDLE on the same edge that consumes the last index; in_ready SHALL be 1 in the next cycle.
- Back-to-back throughput: one mask per (popcount+1) cycles.
REQ-024 in_valid during SCAN SHALL be ignored; the input mask SHALL NOT be sampled.

Reset
REQ-025 Asserting reset SHALL immediately force the following, regardless of clock:
- state=IDLE, mask register=0, out_valid=0, out_index=0, out_last=0, zero_mask=0, busy=0, in_ready=1, pop_count=0.
REQ-026 Reset asserted mid-SCAN SHALL discard the remaining indices; no index SHALL be emitted after reset deasserts until a new mask is accepted.

Configuration
REQ-027 Macro BIT_SCAN_COUNT_EN SHALL control the pop_count feature.
- Defined: pop_count exists and registers the popcount of each accepted mask (zero masks included, giving 0). It updates on the acceptance edge and holds until the next acceptance.
- Undefined: the pop_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-028 Accept mask 32'h00000015 with out_ready=1 held -> indices 0, 2, 4 on consecutive cycles; out_last=1 only with index 4; in_ready=1 the following cycle.
REQ-029 Accept mask 32'h0 -> zero_mask=1 for exactly one cycle, out_valid stays 0, in_ready stays 1; with BIT_SCAN_COUNT_EN, pop_count=0.
REQ-030 Accept mask 32'h80000001 and hold out_ready=0 for 3 cycles -> out_index=0 stable for 3 cycles. Then raise out_ready -> index 31 follows with out_last=1.
REQ-031 Accept mask 32'hFFFFFFFF with in_valid held high and a new mask 32'h2 presented throughout -> 32 ascending indices, no acceptance during SCAN. Mask 32'h2 is accepted after the last index and yields index 1.
REQ-032 Accept mask 32'h000000F0, consume index 4, then assert reset -> all outputs at reset values immediately. After release, no out_valid until a new mask is accepted.
REQ-033 With BIT_SCAN_COUNT_EN, accept mask 32'hF0F0F0F0 -> pop_count=16 from the cycle after acceptance through the whole scan.

Source files
------------

// File: rtl/bit_scan_unit.sv
// Decomposes a 32-bit mask into the ascending indices of its set bits, one index per handshake.
// Optional feature: define BIT_SCAN_COUNT_EN to add the pop_count output.
module bit_scan_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        zero_mask,
    output logic        busy,
`ifdef BIT_SCAN_COUNT_EN
    output logic [5:0]  pop_count,
`endif
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mask_q, mask_d;
    logic        zero_q, zero_d;

    // Handshakes: a transfer happens on a rising edge only when valid and ready are both 1;
    // valid never depends on ready, and payload holds stable while valid=1 and ready=0.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign busy      = (state_q == SCAN);
    assign zero_mask = zero_q;
    assign state_dbg = state_q;

    always_comb begin
        out_index = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mask_q[i]) out_index = 5'(i);
        end
    end

    // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing.
    assign out_last = (mask_q != 32'd0) && ((mask_q & (mask_q - 32'd1)) == 32'd0);

`ifdef BIT_SCAN_COUNT_EN
    logic [5:0] pop_q, pop_d, in_ones;

    always_comb begin
        in_ones = '0;
        for (int i = 0; i < 32; i++) begin
            in_ones = in_ones + {5'd0, in_mask[i]};
        end
    end

    assign pop_count = pop_q;
`endif

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        zero_d  = 1'b0;
`ifdef BIT_SCAN_COUNT_EN
        pop_d   = pop_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef BIT_SCAN_COUNT_EN
                    pop_d = in_ones;
`endif
                    if (in_mask != 32'd0) begin
                        mask_d  = in_mask;
                        state_d = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    mask_d = mask_q & (mask_q - 32'd1);
                    if (out_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            zero_q  <= zero_d;
        end
    end

`ifdef BIT_SCAN_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pop_q <= '0;
        else       pop_q <= pop_d;
    end
`endif

endmodule

// File: tb/tb_bit_scan_unit.sv
// Randomized and directed bench for bit_scan_unit against a queue-based reference model.
module tb_bit_scan_unit;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic        zero_mask;
    logic        busy;
    logic        state_dbg;
`ifdef BIT_SCAN_COUNT_EN
    logic [5:0]  pop_count;
`endif

    bit_scan_unit dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .zero_mask (zero_mask),
        .busy      (busy),
`ifdef BIT_SCAN_COUNT_EN
        .pop_count (pop_count),
`endif
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Scoreboard and reference model state
    logic [4:0] exp_q[$];
    bit         m_busy;
    bit         m_zero;
    int         m_pop;
    int         n_checks;
    int         n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        check("in_ready",  {31'd0, in_ready},  {31'd0, !m_busy});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
        check("busy",      {31'd0, busy},      {31'd0, m_busy});
        check("zero_mask", {31'd0, zero_mask}, {31'd0, m_zero});
        if (m_busy && exp_q.size() > 0) begin
            check("out_index", {27'd0, out_index}, {27'd0, exp_q[0]});
            check("out_last",  {31'd0, out_last},  {31'd0, exp_q.size() == 1});
        end
`ifdef BIT_SCAN_COUNT_EN
        check("pop_count", {26'd0, pop_count}, 32'(m_pop));
`endif
    endtask

    // Driver: check current cycle, then offer inputs for the next rising edge and advance the model.
    task automatic step(input logic v, input logic [31:0] m, input logic r);
        @(negedge clock);
        check_outputs();
        in_valid  = v;
        in_mask   = m;
        out_ready = r;
        m_zero = 1'b0;
        if (!m_busy) begin
            if (v) begin
                m_pop = 0;
                for (int i = 0; i < 32; i++) begin
                    if ((m >> i) & 32'd1) begin
                        exp_q.push_back(5'(i));
                        m_pop++;
                    end
                end
                if (m_pop == 0) m_zero = 1'b1;
                else            m_busy = 1'b1;
            end
        end else if (r) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_busy = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_index"}, {27'd0, out_index}, 32'd0);
        check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
        check({tag, "_zero_mask"}, {31'd0, zero_mask}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
`ifdef BIT_SCAN_COUNT_EN
        check({tag, "_pop_count"}, {26'd0, pop_count}, 32'd0);
`endif
    endtask

    function automatic logic [31:0] rand_mask();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'd1 << $urandom_range(0, 31);
            2:       return $urandom() & $urandom() & $urandom();
            default: return $urandom();
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_busy   = 1'b0;
        m_zero   = 1'b0;
        m_pop    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;
        #1;
        check_reset_values("por");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // 0x15 with out_ready held: indices 0, 2, 4
        step(1'b1, 32'h0000_0015, 1'b1);
        repeat (4) step(1'b0, 32'd0, 1'b1);

        // Zero mask: one-cycle zero_mask pulse, stays idle
        step(1'b1, 32'd0, 1'b1);
        repeat (3) step(1'b0, 32'd0, 1'b1);

        // Back-pressure hold, then release
        step(1'b1, 32'h8000_0001, 1'b0);
        repeat (3) step(1'b0, 32'd0, 1'b0);
        repeat (3) step(1'b0, 32'd0, 1'b1);

        // Single top bit
        step(1'b1, 32'h8000_0000, 1'b1);
        repeat (2) step(1'b0, 32'd0, 1'b1);

        // Full mask with a competing mask offered throughout the scan
        step(1'b1, 32'hFFFF_FFFF, 1'b1);
        repeat (34) step(1'b1, 32'h0000_0002, 1'b1);
        repeat (3) step(1'b0, 32'd0, 1'b1);

        // Popcount of a patterned mask held across the scan
        step(1'b1, 32'hF0F0_F0F0, 1'b1);
        repeat (18) step(1'b0, 32'd0, 1'b1);

        // Reset in the middle of a scan
        step(1'b1, 32'h0000_00F0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_values("mid_rst");
        exp_q.delete();
        m_busy = 1'b0;
        m_zero = 1'b0;
        m_pop  = 0;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) step(1'b0, 32'd0, 1'b1);

        // Random traffic with random back-pressure
        repeat (600) begin
            step($urandom_range(0, 2) != 0, rand_mask(), $urandom_range(0, 9) < 7);
        end
        repeat (40) step(1'b0, 32'd0, 1'b1);
        @(negedge clock);
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
